// File: rtl/regfile_np_pkg.sv
// Shared definitions for the regfile_np register file: default geometry,
// the hardwired-zero address and the legal-write qualification used by both
// the write decode and the read-during-write forwarding path.
package regfile_np_pkg;

  localparam int REGFILE_WIDTH_DEF = 32;
  localparam int REGFILE_DEPTH_DEF = 32;
  localparam int unsigned ZERO_ADDR = 0;

  // A write is legal when it targets an existing entry that is not the
  // hardwired-zero register.
  function automatic logic write_legal(input int unsigned addr,
                                       input int unsigned depth,
                                       input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_np_reg_n.sv
// reg_n: WIDTH-bit register with load enable and synchronous clear.
// Clear has priority over enable, so a reset edge wins over a concurrent write.
module reg_n #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage update: clear first, then optional load.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_np.sv
// regfile_np: DEPTH x WIDTH register file, one synchronous write port and two
// independent combinational read ports. Register 0 is hardwired to zero when
// ZERO_REG=1; out-of-range reads return 0 and out-of-range writes are dropped.
// Optional read-during-write forwarding is enabled by defining the macro
// REGFILE_NP_BYPASS_EN.
module regfile_np
  import regfile_np_pkg::*;
#(
  parameter  int WIDTH    = REGFILE_WIDTH_DEF,
  parameter  int DEPTH    = REGFILE_DEPTH_DEF,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b
);

  logic             wr_ok;
  logic [DEPTH-1:0] wsel;
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;
  logic [WIDTH-1:0] q [DEPTH];
  logic [WIDTH-1:0] mux_a;
  logic [WIDTH-1:0] mux_b;

  // Write qualification shared by the decode and the forwarding path.
  assign wr_ok = we && write_legal(32'(waddr), DEPTH, (ZERO_REG != 0));

  // One register per entry; entry 0 is a constant when hardwired to zero.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wsel[i]  = wr_ok && (waddr == ADDR_W'(i));
    assign hit_a[i] = (raddr_a == ADDR_W'(i));
    assign hit_b[i] = (raddr_b == ADDR_W'(i));
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      reg_n #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .clr (reset),
        .en  (wsel[i]),
        .d   (wdata),
        .q   (q[i])
      );
    end
  end

  // AND-OR read selectors: an address with no matching entry yields 0,
  // so unused address codes can never produce X.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_a[i]) mux_a = mux_a | q[i];
      if (hit_b[i]) mux_b = mux_b | q[i];
    end
  end

`ifdef REGFILE_NP_BYPASS_EN
  // Forward the in-flight write data to any port reading the written entry.
  always_comb begin
    rdata_a = mux_a;
    rdata_b = mux_b;
    if (wr_ok && !reset && (raddr_a == waddr)) rdata_a = wdata;
    if (wr_ok && !reset && (raddr_b == waddr)) rdata_b = wdata;
  end
`else
  // No forwarding: reads show stored contents until the write edge.
  always_comb begin
    rdata_a = mux_a;
    rdata_b = mux_b;
  end
`endif

endmodule

// File: tb/tb_regfile_np.sv
// Testbench for regfile_np. Three instances cover the default 32x32 file with
// a zero register, a non-power-of-two depth (20), and a narrow 8x4 file with
// ZERO_REG=0. Drivers push expected read data into a queue; a monitor on the
// falling edge pops and compares against the observed read ports.
module tb_regfile_np;

  logic clk;
  logic reset;

  // Instance a: WIDTH=32, DEPTH=32, ZERO_REG=1
  logic        a_we;
  logic [4:0]  a_waddr, a_raddr_a, a_raddr_b;
  logic [31:0] a_wdata, a_rdata_a, a_rdata_b;
  // Instance s: WIDTH=32, DEPTH=20, ZERO_REG=1
  logic        s_we;
  logic [4:0]  s_waddr, s_raddr_a, s_raddr_b;
  logic [31:0] s_wdata, s_rdata_a, s_rdata_b;
  // Instance t: WIDTH=8, DEPTH=4, ZERO_REG=0
  logic        t_we;
  logic [1:0]  t_waddr, t_raddr_a, t_raddr_b;
  logic [7:0]  t_wdata, t_rdata_a, t_rdata_b;

  regfile_np #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset(reset), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .raddr_a(a_raddr_a), .raddr_b(a_raddr_b), .rdata_a(a_rdata_a), .rdata_b(a_rdata_b)
  );

  regfile_np #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1)) dut_s (
    .clk(clk), .reset(reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .raddr_a(s_raddr_a), .raddr_b(s_raddr_b), .rdata_a(s_rdata_a), .rdata_b(s_rdata_b)
  );

  regfile_np #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0)) dut_t (
    .clk(clk), .reset(reset), .we(t_we), .waddr(t_waddr), .wdata(t_wdata),
    .raddr_a(t_raddr_a), .raddr_b(t_raddr_b), .rdata_a(t_rdata_a), .rdata_b(t_rdata_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [31:0] exp_q[$];
  int          sel_q[$];
  int          checks   = 0;
  int          failures = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "a.rdata_a";
      1: return "a.rdata_b";
      2: return "s.rdata_a";
      3: return "s.rdata_b";
      4: return "t.rdata_a";
      default: return "t.rdata_b";
    endcase
  endfunction

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] obs;
    int          s;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      case (s)
        0: obs = a_rdata_a;
        1: obs = a_rdata_b;
        2: obs = s_rdata_a;
        3: obs = s_rdata_b;
        4: obs = {24'b0, t_rdata_a};
        default: obs = {24'b0, t_rdata_b};
      endcase
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL %s raddr_a=%0d/%0d/%0d got=%08h exp=%08h", sel_name(s),
                 a_raddr_a, s_raddr_a, t_raddr_a, obs, e);
      end
    end
  end

  // Driver tasks. Each starts and ends 1 time unit after a rising edge.
  task automatic drive_wr(input int inst, input logic en, input int addr, input logic [31:0] d);
    case (inst)
      0: begin a_we = en; a_waddr = 5'(addr); a_wdata = d; end
      1: begin s_we = en; s_waddr = 5'(addr); s_wdata = d; end
      default: begin t_we = en; t_waddr = 2'(addr); t_wdata = d[7:0]; end
    endcase
  endtask

  task automatic drive_rd(input int inst, input int ra, input int rb);
    case (inst)
      0: begin a_raddr_a = 5'(ra); a_raddr_b = 5'(rb); end
      1: begin s_raddr_a = 5'(ra); s_raddr_b = 5'(rb); end
      default: begin t_raddr_a = 2'(ra); t_raddr_b = 2'(rb); end
    endcase
  endtask

  task automatic push_exp(input int sel, input logic [31:0] v);
    sel_q.push_back(sel);
    exp_q.push_back(v);
  endtask

  task automatic do_write(input int inst, input int addr, input logic [31:0] d);
    drive_wr(inst, 1'b1, addr, d);
    @(posedge clk); #1;
    drive_wr(inst, 1'b0, 0, 32'h0);
  endtask

  task automatic expect_rd(input int inst, input int ra, input int rb,
                           input logic [31:0] ea, input logic [31:0] eb);
    drive_rd(inst, ra, rb);
    push_exp(inst * 2, ea);
    push_exp(inst * 2 + 1, eb);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    drive_wr(0, 1'b0, 0, 0); drive_wr(1, 1'b0, 0, 0); drive_wr(2, 1'b0, 0, 0);
    drive_rd(0, 0, 0); drive_rd(1, 0, 0); drive_rd(2, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Every address reads 0 after reset on both ports
    for (int i = 0; i < 32; i++) expect_rd(0, i, 31 - i, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) expect_rd(2, i, 3 - i, 32'h0, 32'h0);

    // Hardwired zero register ignores writes
    do_write(0, 0, 32'hDEADBEEF);
    expect_rd(0, 0, 0, 32'h0, 32'h0);

    // Consecutive writes, then independent and shared reads
    do_write(0, 5, 32'h12345678);
    do_write(0, 31, 32'hCAFEF00D);
    expect_rd(0, 5, 31, 32'h12345678, 32'hCAFEF00D);
    expect_rd(0, 5, 5, 32'h12345678, 32'h12345678);
    expect_rd(0, 31, 4, 32'hCAFEF00D, 32'h0);

    // Read during write to reg 7
    do_write(0, 7, 32'hAAAA0000);
    drive_wr(0, 1'b1, 7, 32'h5555FFFF);
    drive_rd(0, 7, 6);
`ifdef REGFILE_NP_BYPASS_EN
    push_exp(0, 32'h5555FFFF);
`else
    push_exp(0, 32'hAAAA0000);
`endif
    push_exp(1, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    drive_wr(0, 1'b0, 0, 32'h0);
    expect_rd(0, 7, 7, 32'h5555FFFF, 32'h5555FFFF);

    // Reset beats a concurrent write; writes resume after reset drops
    do_write(0, 3, 32'h1);
    expect_rd(0, 3, 0, 32'h1, 32'h0);
    reset = 1'b1;
    drive_wr(0, 1'b1, 3, 32'hFFFFFFFF);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_wr(0, 1'b0, 0, 32'h0);
    expect_rd(0, 3, 5, 32'h0, 32'h0);
    expect_rd(0, 7, 31, 32'h0, 32'h0);
    do_write(0, 3, 32'hFFFFFFFF);
    expect_rd(0, 3, 3, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // DEPTH=20: out-of-range write is dropped, out-of-range reads return 0
    do_write(1, 19, 32'h00000019);
    do_write(1, 25, 32'h00000077);
    expect_rd(1, 25, 19, 32'h0, 32'h19);
    expect_rd(1, 31, 20, 32'h0, 32'h0);
    for (int i = 1; i < 19; i++) expect_rd(1, i, 0, 32'h0, 32'h0);

    // WIDTH=8, DEPTH=4: last write wins; neighbours untouched; reg 0 writable
    do_write(2, 3, 32'hA5);
    do_write(2, 3, 32'h3C);
    expect_rd(2, 3, 1, 32'h3C, 32'h0);
    expect_rd(2, 2, 3, 32'h0, 32'h3C);
    do_write(2, 0, 32'h11);
    expect_rd(2, 0, 3, 32'h11, 32'h3C);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
